// File: rtl/rr_arbiter4.sv
// Four-requester arbiter with round-robin or fixed priority. The winner's data
// is captured into a registered output stage with a valid/ready handshake.
module rr_arbiter4 #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mode_i,
  input  logic [3:0]       req_i,
  input  logic [Width-1:0] in1_i,
  input  logic [Width-1:0] in2_i,
  input  logic [Width-1:0] in3_i,
  input  logic [Width-1:0] in4_i,
  output logic [3:0]       ack_o,
  output logic [Width-1:0] out_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [1:0]       sel_o
);

  logic [1:0]       ptr_q, ptr_d;
  logic [Width-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [1:0]       sel_q, sel_d;

  logic [3:0]       rot_req;
  logic [1:0]       rot_off;
  logic [1:0]       fix_win;
  logic [1:0]       win;
  logic             accept;
  logic [Width-1:0] win_data;

  // rot_req[i] is the request at position ptr+i, so the lowest set bit of
  // rot_req is the round-robin winner's offset from the pointer.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_req[gi] = req_i[ptr_q + 2'(gi)];
  end

  always_comb begin
    rot_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) rot_off = 2'(i);
    end
  end

  always_comb begin
    fix_win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_i[i]) fix_win = 2'(i);
    end
  end

  assign win    = mode_i ? fix_win : (ptr_q + rot_off);
  assign accept = (!valid_q || ready_i) && (|req_i) && !rst_i;
  assign ack_o  = accept ? (4'b0001 << win) : 4'b0000;

  always_comb begin
    case (win)
      2'd0:    win_data = in1_i;
      2'd1:    win_data = in2_i;
      2'd2:    win_data = in3_i;
      default: win_data = in4_i;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    out_d   = out_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    if (accept) begin
      out_d   = win_data;
      sel_d   = win;
      valid_d = 1'b1;
      if (!mode_i) ptr_d = win + 2'd1;
    end else if (valid_q && ready_i) begin
      // Word leaves without a replacement; data and index stay as they were.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= 2'd0;
      out_q   <= '0;
      valid_q <= 1'b0;
      sel_q   <= 2'd0;
    end else begin
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign out_o   = out_q;
  assign valid_o = valid_q;
  assign sel_o   = sel_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed vector table from the test plan, then random
// traffic against a behavioural model with a fairness watch.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst, mode, ready;
  logic [3:0] req;
  logic [7:0] in1, in2, in3, in4;
  logic [3:0] ack;
  logic [7:0] out;
  logic       valid;
  logic [1:0] sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.Width(8)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .req_i(req),
    .in1_i(in1), .in2_i(in2), .in3_i(in3), .in4_i(in4),
    .ack_o(ack), .out_o(out), .valid_o(valid), .ready_i(ready), .sel_o(sel)
  );

  typedef struct {
    logic       rst;
    logic       mode;
    logic [3:0] req;
    logic       ready;
    logic [3:0] e_ack;
    logic       e_valid;
    logic [7:0] e_out;
    logic [1:0] e_sel;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic m, input logic [3:0] q, input logic rd,
                              input logic [3:0] a, input logic v, input logic [7:0] o, input logic [1:0] s);
    vec_t t;
    t.rst = r; t.mode = m; t.req = q; t.ready = rd;
    t.e_ack = a; t.e_valid = v; t.e_out = o; t.e_sel = s;
    vecs.push_back(t);
  endfunction

  // Behavioural model state
  int m_ptr, m_sel, m_out;
  bit m_valid;
  int wait_cnt[4];
  byte data_tab[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    in1 = 8'h11; in2 = 8'h22; in3 = 8'h33; in4 = 8'h44;
    rst = 1'b1; mode = 1'b0; req = 4'b0; ready = 1'b0;

    // reset, then round-robin stream
    add(1,0,4'b1111,1, 4'b0000,0,8'h00,0);
    add(1,0,4'b1111,1, 4'b0000,0,8'h00,0);
    add(0,0,4'b1111,1, 4'b0001,0,8'h00,0);
    add(0,0,4'b1111,1, 4'b0010,1,8'h11,0);
    add(0,0,4'b1111,1, 4'b0100,1,8'h22,1);
    add(0,0,4'b1111,1, 4'b1000,1,8'h33,2);
    add(0,0,4'b1111,1, 4'b0001,1,8'h44,3);
    add(0,0,4'b1111,1, 4'b0010,1,8'h11,0);
    // backpressure for 5 cycles, then release
    for (int i = 0; i < 5; i++) add(0,0,4'b1111,0, 4'b0000,1,8'h22,1);
    add(0,0,4'b1111,1, 4'b0100,1,8'h22,1);
    add(0,0,4'b0000,1, 4'b0000,1,8'h33,2);
    add(0,0,4'b0000,1, 4'b0000,0,8'h33,2);
    // fixed priority with requesters 1 and 3
    add(0,1,4'b1010,1, 4'b0010,0,8'h33,2);
    for (int i = 0; i < 7; i++) add(0,1,4'b1010,1, 4'b0010,1,8'h22,1);
    // back to round-robin: pointer kept its value of 3
    add(0,0,4'b1111,1, 4'b1000,1,8'h22,1);
    add(0,0,4'b0000,1, 4'b0000,1,8'h44,3);
    // pointer wrap after reset
    add(1,0,4'b0000,1, 4'b0000,0,8'h44,3);
    add(0,0,4'b1001,1, 4'b0001,0,8'h00,0);
    add(0,0,4'b1001,1, 4'b1000,1,8'h11,0);
    add(0,0,4'b1001,1, 4'b0001,1,8'h44,3);
    add(0,0,4'b1001,1, 4'b1000,1,8'h11,0);
    add(0,0,4'b0000,1, 4'b0000,1,8'h44,3);
    // reset while holding 0x33 under backpressure
    add(0,0,4'b0100,1, 4'b0100,0,8'h44,3);
    add(0,0,4'b0000,0, 4'b0000,1,8'h33,2);
    add(1,0,4'b1111,0, 4'b0000,1,8'h33,2);
    add(0,0,4'b1100,1, 4'b0100,0,8'h00,0);
    add(0,0,4'b0000,1, 4'b0000,1,8'h33,2);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; mode = vecs[i].mode; req = vecs[i].req; ready = vecs[i].ready;
      @(negedge clk);
      chk("dir_ack",   i, 32'(ack),   32'(vecs[i].e_ack));
      chk("dir_valid", i, 32'(valid), 32'(vecs[i].e_valid));
      chk("dir_out",   i, 32'(out),   32'(vecs[i].e_out));
      chk("dir_sel",   i, 32'(sel),   32'(vecs[i].e_sel));
      $display("dir %0d rst=%0b mode=%0b req=%b rdy=%0b ack=%b valid=%0b out=%h sel=%0d",
               i, rst, mode, req, ready, ack, valid, out, sel);
      @(posedge clk); #1;
    end

    // Random phase: start from a known reset shared with the model.
    rst = 1'b1; req = 4'b0; ready = 1'b0;
    @(posedge clk); #1;
    m_ptr = 0; m_sel = 0; m_out = 0; m_valid = 0;
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;

    for (int n = 0; n < 600; n++) begin
      int  win;
      bit  acc;
      logic [3:0] e_ack;
      rst   = ($urandom_range(0, 39) == 0);
      mode  = ($urandom_range(0, 7) == 0);
      req   = 4'($urandom);
      ready = ($urandom_range(0, 3) != 0);

      acc = (!m_valid || ready) && (req != 0) && !rst;
      win = 0;
      if (mode) begin
        for (int k = 3; k >= 0; k--) if (req[k]) win = k;
      end else begin
        for (int k = 3; k >= 0; k--) if (req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      end
      e_ack = acc ? 4'(1 << win) : 4'b0000;

      @(negedge clk);
      chk("rnd_ack",   n, 32'(ack),   32'(e_ack));
      chk("rnd_valid", n, 32'(valid), 32'(m_valid));
      chk("rnd_out",   n, 32'(out),   32'(m_out));
      chk("rnd_sel",   n, 32'(sel),   32'(m_sel));
      $display("rnd %0d rst=%0b mode=%0b req=%b rdy=%0b ack=%b valid=%0b out=%h sel=%0d",
               n, rst, mode, req, ready, ack, valid, out, sel);

      // Fairness in round-robin: a held request waits at most 3 other grants.
      for (int k = 0; k < 4; k++) begin
        if (!req[k] || rst || mode) wait_cnt[k] = 0;
        else if (acc && win == k) wait_cnt[k] = 0;
        else if (acc) begin
          wait_cnt[k]++;
          chk("rr_fair", n, 32'(wait_cnt[k] > 3), 32'd0);
        end
      end

      if (rst) begin
        m_ptr = 0; m_sel = 0; m_out = 0; m_valid = 0;
      end else if (acc) begin
        m_out = data_tab[win]; m_sel = win; m_valid = 1;
        if (!mode) m_ptr = (win + 1) % 4;
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
